bus_select_decoder: RTL and testbench

- Sequenced 5-to-32 one-hot decoder for the CPU internal bus.
- Accepts a 5-bit source-select code through a valid/ready handshake.
- Drives exactly one registered bus-drive enable for HOLD cycles, then releases the bus, with an optional turnaround gap.
- Sits between control-unit sequencing and the register-file/ALU tri-state drive enables, as the inverse of the bus-request encoder.

---
 rtl/bus_select_decoder.sv | 126 ++++++++++++
 tb/tb_bus_select_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_select_decoder.sv
// bus_select_decoder
//   Sequenced 5-to-32 one-hot decoder for the CPU internal bus. A source-select
//   code is accepted through a valid/ready handshake. The matching registered
//   drive enable is then held for HOLD cycles, after which the bus is released.
//   This block is the inverse of the bus-request encoder.
//
//   Optional feature: define BUS_TURNAROUND_EN to compile in the GAP state.
//   GAP adds one dead bus cycle after every DRIVE, aborted or not, so that two
//   sources never overlap on the bus.
//
// Parameters
//   HOLD       cycles the selected enable stays asserted (1..255)
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   sel_code   [4:0] source-select code; code n drives drive_en[n]
//   sel_valid  request qualifier, sampled together with sel_ready
//   sel_ready  registered; high only in IDLE
//   abort      synchronous cancel of an active drive
//   drive_en   [31:0] registered one-hot drive enable, zero when idle
//   busy       high in any state other than IDLE
//   done       one-cycle pulse in the last DRIVE cycle of an unaborted transfer
module bus_select_decoder #(
  parameter int unsigned HOLD = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  sel_code,
  input  logic        sel_valid,
  output logic        sel_ready,
  input  logic        abort,
  output logic [31:0] drive_en,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1
`ifdef BUS_TURNAROUND_EN
    ,GAP  = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] drive_en_q, drive_en_d;
  logic        sel_ready_q, sel_ready_d;
  logic [31:0] onehot;
  logic        accept;

  // Per-bit compare. Each lane matches exactly one code, so the result
  // cannot be multi-hot.
  for (genvar n = 0; n < 32; n++) begin : g_dec
    assign onehot[n] = (sel_code == 5'(n));
  end

  assign accept = sel_valid & sel_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drive_en_d = drive_en_q;
    case (state_q)
      IDLE: begin
        drive_en_d = '0;
        if (accept) begin
          state_d    = DRIVE;
          cnt_d      = HOLD_M1;
          drive_en_d = onehot;
        end
      end
      DRIVE: begin
        // An abort ends the drive exactly as if the count had run out.
        if (abort || cnt_q == 8'd0) begin
`ifdef BUS_TURNAROUND_EN
          state_d  = GAP;
`else
          state_d  = IDLE;
`endif
          cnt_d      = 8'd0;
          drive_en_d = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef BUS_TURNAROUND_EN
      GAP: begin
        state_d    = IDLE;
        drive_en_d = '0;
      end
`endif
      default: begin
        state_d    = IDLE;
        cnt_d      = 8'd0;
        drive_en_d = '0;
      end
    endcase
    // Ready is registered, so it reflects the state being entered.
    sel_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      drive_en_q  <= '0;
      sel_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drive_en_q  <= drive_en_d;
      sel_ready_q <= sel_ready_d;
    end
  end

  assign drive_en  = drive_en_q;
  assign sel_ready = sel_ready_q;
  assign busy      = (state_q != IDLE);
  // The pulse depends on abort combinationally, so an abort in the final
  // cycle suppresses it.
  assign done      = (state_q == DRIVE) && (cnt_q == 8'd0) && !abort;

endmodule

// File: tb/tb_bus_select_decoder.sv
// Testbench for bus_select_decoder. Five instances share one clock and reset.
// Instance g is built with HOLD = g+1 and is only exercised through its own
// sel_valid bit.
module tb_bus_select_decoder;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  code = '0;
  logic        abort = 1'b0;
  logic [4:0]  valid = '0;
  logic [4:0]  rdy, bsy, dn;
  logic [31:0] den [5];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    bus_select_decoder #(.HOLD(g + 1)) u_dut (
      .clk(clk), .clr(clr), .sel_code(code), .sel_valid(valid[g]),
      .sel_ready(rdy[g]), .abort(abort), .drive_en(den[g]),
      .busy(bsy[g]), .done(dn[g])
    );
  end

  // One-hot invariant on every instance, every cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 5; g++) begin
      checks++;
      if ($countones(den[g]) > 1) begin
        errors++;
        $display("FAIL onehot inst%0d drive_en=%h", g, den[g]);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; valid[0] = 1'b1; code = 5'd5;
    repeat (2) step();
    checks++; if (den[0] !== 32'h0) begin errors++; $display("FAIL rst_den got %h exp 0", den[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b exp 1", rdy[0]); end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bsy[0]); end
    checks++; if (dn[0] !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", dn[0]); end
    clr = 1'b1;
    step();
    checks++; if (den[0] !== 32'h0000_0020) begin errors++; $display("FAIL rst_first_accept got %h exp 00000020", den[0]); end
    checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL rst_first_busy got %b exp 1", bsy[0]); end
    valid[0] = 1'b0;
    step();
`ifdef BUS_TURNAROUND_EN
    step();
`endif
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rst_ready_back got %b exp 1", rdy[0]); end
  endtask

  task automatic test_sweep();
    logic [31:0] exp;
    for (int c = 0; c < 32; c++) begin
      exp = 32'h1 << c;
      code = 5'(c); valid[0] = 1'b1;
      step();
      valid[0] = 1'b0;
      checks++; if (den[0] !== exp) begin errors++; $display("FAIL sweep_den code %0d got %h exp %h", c, den[0], exp); end
      checks++; if (dn[0] !== 1'b1) begin errors++; $display("FAIL sweep_done code %0d got %b exp 1", c, dn[0]); end
      checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL sweep_rdy_lo code %0d got %b exp 0", c, rdy[0]); end
      step();
      checks++; if (den[0] !== 32'h0) begin errors++; $display("FAIL sweep_release code %0d got %h exp 0", c, den[0]); end
`ifdef BUS_TURNAROUND_EN
      checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL sweep_gap_rdy code %0d got %b exp 0", c, rdy[0]); end
      step();
`endif
      checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL sweep_rdy_hi code %0d got %b exp 1", c, rdy[0]); end
    end
  endtask

  task automatic test_hold3();
    code = 5'd12; valid[2] = 1'b1;
    step();
    valid[2] = 1'b0; code = 5'd7;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (den[2] !== 32'h0000_1000) begin errors++; $display("FAIL hold3_den cyc %0d got %h exp 00001000", i, den[2]); end
      checks++; if (dn[2] !== (i == 3)) begin errors++; $display("FAIL hold3_done cyc %0d got %b exp %b", i, dn[2], (i == 3)); end
      step();
    end
    checks++; if (den[2] !== 32'h0) begin errors++; $display("FAIL hold3_release got %h exp 0", den[2]); end
    checks++; if (dn[2] !== 1'b0) begin errors++; $display("FAIL hold3_done_after got %b exp 0", dn[2]); end
`ifdef BUS_TURNAROUND_EN
    step();
`endif
    checks++; if (bsy[2] !== 1'b0) begin errors++; $display("FAIL hold3_idle got busy %b exp 0", bsy[2]); end
  endtask

  task automatic test_abort();
    code = 5'd31; valid[3] = 1'b1;
    step();
    valid[3] = 1'b0;
    checks++; if (den[3] !== 32'h8000_0000) begin errors++; $display("FAIL abort_den1 got %h exp 80000000", den[3]); end
    step();
    abort = 1'b1; #1;
    checks++; if (den[3] !== 32'h8000_0000) begin errors++; $display("FAIL abort_den2 got %h exp 80000000", den[3]); end
    checks++; if (dn[3] !== 1'b0) begin errors++; $display("FAIL abort_done2 got %b exp 0", dn[3]); end
    step();
    abort = 1'b0;
    checks++; if (den[3] !== 32'h0) begin errors++; $display("FAIL abort_release got %h exp 0", den[3]); end
`ifdef BUS_TURNAROUND_EN
    checks++; if (bsy[3] !== 1'b1) begin errors++; $display("FAIL abort_gap_busy got %b exp 1", bsy[3]); end
    step();
`endif
    checks++; if (bsy[3] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bsy[3]); end
    checks++; if (dn[3] !== 1'b0) begin errors++; $display("FAIL abort_done_after got %b exp 0", dn[3]); end
    // Abort landing on the final count of HOLD=2 must still kill done.
    code = 5'd9; valid[1] = 1'b1;
    step();
    valid[1] = 1'b0;
    step();
    abort = 1'b1; #1;
    checks++; if (dn[1] !== 1'b0) begin errors++; $display("FAIL abort_last_done got %b exp 0", dn[1]); end
    checks++; if (den[1] !== 32'h0000_0200) begin errors++; $display("FAIL abort_last_den got %h exp 00000200", den[1]); end
    step();
    abort = 1'b0;
    checks++; if (den[1] !== 32'h0) begin errors++; $display("FAIL abort_last_release got %h exp 0", den[1]); end
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    valid[1] = 1'b1; code = 5'd3;
    step();
    code = 5'd24;
    checks++; if (den[1] !== 32'h8) begin errors++; $display("FAIL b2b_c1 got %h exp 8", den[1]); end
    step();
    checks++; if (den[1] !== 32'h8) begin errors++; $display("FAIL b2b_c2 got %h exp 8", den[1]); end
    step();
    checks++; if (den[1] !== 32'h0) begin errors++; $display("FAIL b2b_c3 got %h exp 0", den[1]); end
`ifdef BUS_TURNAROUND_EN
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL b2b_gap_rdy got %b exp 0", rdy[1]); end
    step();
    checks++; if (den[1] !== 32'h0) begin errors++; $display("FAIL b2b_c4 got %h exp 0", den[1]); end
`endif
    checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL b2b_idle_rdy got %b exp 1", rdy[1]); end
    step();
    valid[1] = 1'b0;
    checks++; if (den[1] !== 32'h0100_0000) begin errors++; $display("FAIL b2b_second got %h exp 01000000", den[1]); end
    repeat (4) step();
  endtask

  task automatic test_async_reset();
    code = 5'd0; valid[4] = 1'b1;
    step();
    valid[4] = 1'b0;
    step();
    checks++; if (den[4] !== 32'h1) begin errors++; $display("FAIL arst_pre got %h exp 1", den[4]); end
    #2 clr = 1'b0;
    #1;
    checks++; if (den[4] !== 32'h0) begin errors++; $display("FAIL arst_den got %h exp 0", den[4]); end
    checks++; if (dn[4] !== 1'b0) begin errors++; $display("FAIL arst_done got %b exp 0", dn[4]); end
    checks++; if (rdy[4] !== 1'b1) begin errors++; $display("FAIL arst_rdy got %b exp 1", rdy[4]); end
    clr = 1'b1;
    step();
    checks++; if (bsy[4] !== 1'b0) begin errors++; $display("FAIL arst_idle got busy %b exp 0", bsy[4]); end
    checks++; if (den[4] !== 32'h0) begin errors++; $display("FAIL arst_den_after got %h exp 0", den[4]); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_hold3();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
